// File: rtl/pdp_mem_pkg.sv
// Shared types and sizing helpers for the PDP-11 on-chip memory path.
// Imported by the wait-state RAM controller and its storage lanes.
package pdp_mem_pkg;

  // Width of the programmable wait-state counter (WAIT_CYCLES is 0..15).
  localparam int WAIT_CW = 4;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int lb_of(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte lane of the RAM: 2**AW x 8 synchronous array, single port,
// registered read of the addressed word every cycle.
module ram_lane #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // NOTE: the array has no reset branch so it maps onto a RAM macro;
  // zeroing after reset is done word by word by the controller's clear.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_ws_ctl.sv
// Byte-addressable RAM with REQ/ACK handshake, programmable wait states,
// alignment-error reporting and optional zero-clear after reset.
module ram_ws_ctl
  import pdp_mem_pkg::*;
#(
  parameter int AW             = 12,
  parameter int DW             = 16,
  parameter int WAIT_CYCLES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    REQ,
  input  logic                    WE,
  input  logic                    BYTE_OP,
  input  logic [AW+lb_of(DW)-1:0] A,
  input  logic [DW-1:0]           DI,
  output logic [DW-1:0]           DO,
  output logic                    ACK,
  output logic                    ODD_ERR,
  output logic                    BUSY
);

  localparam int LANES = lanes_of(DW);
  localparam int LB    = lb_of(DW);

  localparam logic [WAIT_CW-1:0] WAIT_INIT =
    WAIT_CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [AW-1:0] LAST_WORD = '1;

  state_e               state;
  logic [WAIT_CW-1:0]   wait_cnt;
  logic [AW-1:0]        clear_cnt;

  logic                 we_q;
  logic                 byte_q;
  logic [AW-1:0]        word_q;
  logic [LB-1:0]        lane_q;
  logic [DW-1:0]        di_q;

  logic [AW-1:0]        ram_addr;
  logic [LANES-1:0]     lane_we;
  logic [LANES-1:0][7:0] lane_wd;
  logic [DW-1:0]        lane_rd;
  logic [DW-1:0]        rd_data;

  logic [AW-1:0]        word_in;
  logic [LB-1:0]        lane_in;

  assign word_in = A[AW+LB-1:LB];
  assign lane_in = A[LB-1:0];

  // In IDLE the live address is presented so the registered read is already
  // valid by the ACCESS cycle; afterwards the latched address is held.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ram_addr = word_q;
    if (state == ST_CLEAR) begin
      ram_addr = clear_cnt;
    end else if (state == ST_IDLE) begin
      ram_addr = word_in;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic sel;

    assign sel        = !byte_q || (lane_q == LB'(i));
    assign lane_we[i] = (state == ST_CLEAR) ||
                        ((state == ST_ACCESS) && we_q && sel);
    assign lane_wd[i] = (state == ST_CLEAR) ? 8'h00 :
                        (byte_q ? di_q[7:0] : di_q[8*i +: 8]);

    ram_lane #(
      .AW(AW)
    ) u_lane (
      .clk   (CLK),
      .we    (lane_we[i]),
      .addr  (ram_addr),
      .wdata (lane_wd[i]),
      .rdata (lane_rd[8*i +: 8])
    );
  end

  always_comb begin
    rd_data = lane_rd;
    if (byte_q) begin
      rd_data = {{(DW-8){1'b0}}, lane_rd[8*lane_q +: 8]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      BUSY      <= (CLEAR_ON_RESET != 0);
      ACK       <= 1'b0;
      ODD_ERR   <= 1'b0;
      DO        <= '0;
      wait_cnt  <= '0;
      clear_cnt <= '0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      word_q    <= '0;
      lane_q    <= '0;
      di_q      <= '0;
    end else begin
      ACK     <= 1'b0;
      ODD_ERR <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == LAST_WORD) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        ST_IDLE: begin
          // The ACK cycle itself never starts a transaction, so a requester
          // that releases REQ on the edge after ACK cannot double-issue.
          if (REQ && !ACK) begin
            we_q   <= WE;
            byte_q <= BYTE_OP;
            word_q <= word_in;
            lane_q <= lane_in;
            di_q   <= DI;
            if (!BYTE_OP && (lane_in != '0)) begin
              state <= ST_ERR;
            end else if (WAIT_CYCLES == 0) begin
              state <= ST_ACCESS;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACCESS: begin
          ACK   <= 1'b1;
          state <= ST_IDLE;
          if (!we_q) begin
            DO <= rd_data;
          end
        end
        ST_ERR: begin
          ACK     <= 1'b1;
          ODD_ERR <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
